// File: rtl/mem_bus_resp_pkg.sv
// Shared types and constants for the CPU-side memory bus responder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_e;

  localparam logic [1:0] SEG_SFR = 2'd0;
  localparam logic [1:0] SEG_IO  = 2'd1;
  localparam logic [1:0] SEG_DFM = 2'd2;
  localparam logic [1:0] SEG_PFM = 2'd3;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;

  // Drop the undef bit so the remaining enables line up with segment indices.
  function automatic logic [3:0] real_seg_en(input logic [4:0] en);
    return {en[4], en[3], en[1], en[0]};
  endfunction

  function automatic logic [1:0] seg_index(input logic [3:0] oh);
    logic [1:0] idx;
    idx = SEG_SFR;
    if (oh[1]) idx = SEG_IO;
    if (oh[2]) idx = SEG_DFM;
    if (oh[3]) idx = SEG_PFM;
    return idx;
  endfunction

endpackage

// File: rtl/mem_bus_resp_if.sv
// CPU request / segment handshake / CPU response signals of the bus responder.
interface mem_bus_resp_if;

  logic             req_valid;
  logic             req_we;
  logic [4:0]       seg_en;
  logic [3:0][31:0] seg_rdata;
  logic [3:0]       seg_ready;
  logic [3:0]       seg_req;
  logic             seg_we;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic             bus_busy;

  modport slave (
    input  req_valid, req_we, seg_en, seg_rdata, seg_ready,
    output seg_req, seg_we, resp_valid, resp_rdata, resp_err, bus_busy
  );

  modport master (
    output req_valid, req_we, seg_en, seg_rdata, seg_ready,
    input  seg_req, seg_we, resp_valid, resp_rdata, resp_err, bus_busy
  );

endinterface

// File: rtl/mem_bus_resp_timeout.sv
// 8-bit WAIT-cycle counter; expired is high while the count equals LIMIT.
module bus_timeout_cnt
  import mem_bus_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cnt_q != '1) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 8'(LIMIT));

endmodule

// File: rtl/mem_bus_resp.sv
// Decodes a CPU access to one of four segments, waits for its ready with a
// timeout, and returns a single-cycle response (error for bad decode/timeout).
module mem_bus_resp
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  mem_bus_resp_if.slave  bus
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        we_q, we_d;
  logic [3:0]  seg_req_q, seg_req_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  seg_oh;
  logic        dec_ok;
  logic        rdy_sel;
  logic        cnt_clr, cnt_en, cnt_expired;

  assign seg_oh  = real_seg_en(bus.seg_en);
  assign dec_ok  = !bus.seg_en[2] && (seg_oh != '0) && ((seg_oh & (seg_oh - 4'd1)) == '0);
  assign rdy_sel = bus.seg_ready[idx_q];

  bus_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    we_d      = we_q;
    seg_req_d = '0;
    rdata_d   = rdata_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (dec_ok) begin
            state_d                   = ST_WAIT;
            idx_d                     = seg_index(seg_oh);
            we_d                      = bus.req_we;
            seg_req_d[seg_index(seg_oh)] = 1'b1;
            cnt_clr                   = 1'b1;
          end else begin
            state_d = ST_ERR;
            rdata_d = ERR_RDATA;
          end
        end
      end
      ST_WAIT: begin
        // Ready is tested before expiry so a coincident ready still completes.
        if (rdy_sel) begin
          state_d = ST_RESP;
          rdata_d = we_q ? '0 : bus.seg_rdata[idx_q];
        end else if (cnt_expired) begin
          state_d = ST_ERR;
          rdata_d = ERR_RDATA;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= SEG_SFR;
      we_q      <= 1'b0;
      seg_req_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      seg_req_q <= seg_req_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.seg_req    = seg_req_q;
  assign bus.seg_we     = we_q;
  assign bus.resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign bus.resp_err   = (state_q == ST_ERR);
  assign bus.resp_rdata = rdata_q;
  assign bus.bus_busy   = (state_q != ST_IDLE);

endmodule

// File: doc/mem_bus_resp.md
MEM_BUS_RESP -- requirements
Module: mem_bus_resp

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, giving the maximum WAIT cycles before a timeout error (legal range 1..255).
REQ-002 SHALL have parameter ERR_RDATA, default 32'h0000_0000, giving the rdata value returned with any error response.
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port sys_clk, input, 1, system clock.
REQ-005 SHALL have port sys_rst, input, 1, async active-high reset.
REQ-006 SHALL have port req_valid, input, 1, CPU access request, sampled only in IDLE.
REQ-007 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port seg_en, input, 5, address-decoder enables, ordered {pfm,dfm,undef,io,sfr} with bit0 = sfr.
REQ-009 SHALL have port seg_rdata, input, 4x32, read data per real segment, indexed sfr, io, dfm, pfm.
REQ-010 SHALL have port seg_ready, input, 4, per-segment completion, same indexing as seg_rdata.
REQ-011 SHALL have port seg_req, output, 4, one-hot single-cycle strobe to the selected segment.
REQ-012 SHALL have port seg_we, output, 1, latched req_we, valid while seg_req is high.
REQ-013 SHALL have port resp_valid, output, 1, single-cycle response strobe to the CPU.
REQ-014 SHALL have port resp_rdata, output, 32, read data, valid with resp_valid.
REQ-015 SHALL have port resp_err, output, 1, error flag, valid with resp_valid.
REQ-016 SHALL have port bus_busy, output, 1, stall indication, high whenever state != IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP, ERR.
REQ-018 IDLE: when req_valid=1 and seg_en is one-hot over {sfr,io,dfm,pfm}, SHALL latch the segment index and req_we, and go to WAIT.
REQ-019 IDLE: when req_valid=1 and seg_en has undef set, is zero, or is not one-hot, SHALL go to ERR.
REQ-020 SHALL drive seg_req[idx]=1 only during the first WAIT cycle.
REQ-021 WAIT: SHALL sample only seg_ready[idx] and ignore all other ready bits.
REQ-022 WAIT: on seg_ready[idx]=1, SHALL register seg_rdata[idx] into resp_rdata (0 for writes) and go to RESP.
REQ-023 WAIT: an 8-bit counter SHALL clear on WAIT entry and increment each WAIT cycle without ready.
REQ-024 WAIT: when the counter reaches TIMEOUT_CYC with ready still low, SHALL go to ERR.
REQ-025 WAIT: if ready and timeout occur in the same cycle, ready SHALL win and the FSM goes to RESP.
REQ-026 RESP: SHALL assert resp_valid=1 and resp_err=0 for exactly one cycle, then go to IDLE.
REQ-027 ERR: SHALL assert resp_valid=1, resp_err=1 and resp_rdata=ERR_RDATA for one cycle, then go to IDLE.
REQ-028 Latency: request at cycle T with ready at T+1 SHALL give resp_valid at T+2 (minimum for real segments).
REQ-029 Latency: a decode error at T SHALL give resp_valid at T+1.
REQ-030 SHALL ignore req_valid outside IDLE; requests are not queued.
REQ-031 A new request SHALL be accepted in the IDLE cycle that immediately follows RESP or ERR.
REQ-032 resp_rdata SHALL hold its last value between responses.

Reset
REQ-033 On sys_rst=1, regardless of clock, SHALL force state=IDLE, counter=0, seg_req=0, seg_we=0, resp_valid=0, resp_err=0, resp_rdata=0 and bus_busy=0.
REQ-034 Reset asserted mid-transaction SHALL abort it with no response; the first request after deassertion SHALL be accepted normally.

Structure
REQ-035 Package mem_bus_pkg SHALL hold the FSM state enum, segment index constants (SEG_SFR=0, SEG_IO=1, SEG_DFM=2, SEG_PFM=3) and the default TIMEOUT_CYC.
REQ-036 The timeout counter SHALL be a separate sub-module named bus_timeout_cnt, with inputs clr and en and output expired.

Verification
REQ-037 PFM read: addr 0x0000_0100, seg_en=5'b10000, pfm ready at T+3 with rdata 0x1234_5678 -> seg_req=4'b1000 at T+1; resp_valid at T+4 with rdata 0x1234_5678 and err=0.
REQ-038 Undefined region: addr 0xC000_0000, seg_en=5'b00100 -> resp_valid at T+1, resp_err=1, rdata=ERR_RDATA, no seg_req pulse.
REQ-039 Timeout: SFR read (addr 0xFFFF_F800, seg_en=5'b00001) with ready held low, TIMEOUT_CYC=4 -> ERR response exactly at the specified cycle; other segments' ready pulses ignored.
REQ-040 Ready/timeout tie: io ready coincides with counter=TIMEOUT_CYC -> normal response with err=0.
REQ-041 Busy rejection: second req_valid during WAIT -> no effect; back-to-back request accepted the cycle after RESP.
REQ-042 Reset mid-WAIT: sys_rst pulse during a DFM access (addr 0x2000_0000) -> outputs zero immediately, no resp_valid; next request completes normally.
